banked_reg_file: RTL
====================

Name: banked_reg_file

Overview:
- Parametrised successor to the single-context register bank.
- Configurable register count and width.
- Banked stack pointer and link register per privilege mode.
- Two registered read ports with optional write-to-read bypass.
- Multi-cycle post-reset initialisation sweep with a busy flag.
- Sits between decode, ALU and memory write-back; sole owner of PC, SP and LR state.

Parameters:
- REG_COUNT, 16: architectural registers; index width RI = clog2(REG_COUNT).
- REGISTER_LENGTH, 32: data width.
- ADDR_WIDTH, 32: PC width; must be <= REGISTER_LENGTH.
- DATA_AREA_START, 8192: value loaded into R0 at init and on clear-stack.
- MAX_NUMBER, all-ones of REGISTER_LENGTH: initial value of both stack pointers.
- SP_INDEX, 14: architectural SP index.
- LR_INDEX, 13: architectural LR index.
- PC_INDEX, 15: architectural PC index.
- RESET_PC, 0: PC after reset.

Ports:
- slow_clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  commit strobe for this cycle's write-back.
- privileged_mode  in  1  selects the banked SP and LR (1 = privileged copy).
- control  in  3  write-back operation, encoded in package.
- register_source_A  in  RI  read port A address.
- register_source_B  in  RI  read port B address.
- register_Dest  in  RI  write/peek address.
- ALU_result  in  REGISTER_LENGTH  ALU write data; also the branch target.
- data_from_memory  in  REGISTER_LENGTH  load write data.
- new_SP  in  REGISTER_LENGTH  next SP for the active mode.
- new_PC  in  ADDR_WIDTH  sequential next PC.
- should_branch  in  1  PC takes ALU_result[ADDR_WIDTH-1:0].
- read_data_A  out  REGISTER_LENGTH  registered port A data.
- read_data_B  out  REGISTER_LENGTH  registered port B data.
- current_PC  out  ADDR_WIDTH  PC.
- current_SP  out  REGISTER_LENGTH  active-mode SP.
- memory_output  out  REGISTER_LENGTH  combinational Rd value for stores; SP_INDEX and LR_INDEX map to banked copies.
- busy  out  1  high during the init sweep.

Behaviour:
- Async reset:
  - state = INIT, sweep counter = 0, busy = 1.
  - PC = RESET_PC, both SPs = MAX_NUMBER, both LRs = 0.
  - read_data_A = read_data_B = 0.
- INIT state:
  - Each cycle, writes 0 to register[counter], except R0, which gets DATA_AREA_START. PC, SP and LR indices are skipped.
  - Counter increments; after the write at REG_COUNT-1, state = RUN and busy = 0 the next cycle. Total busy time is exactly REG_COUNT cycles.
  - enable, control and reads are ignored; read outputs hold 0.
- RUN state:
  - Reads: read_data_X updates every edge with the value of register_source_X, so latency is 1 cycle.
  - Reads of SP_INDEX and LR_INDEX return the active-mode banked copy. A read of PC_INDEX returns the zero-extended PC.
- On the edge with enable = 1:
  - PC <= should_branch ? ALU_result : new_PC.
  - Active SP <= (control == CLR_STACK) ? MAX_NUMBER : new_SP.
  - control 0 NOP: no register write.
  - control 1 WB_ALU: Rd <= ALU_result.
  - control 2 CLR_STACK: R0 <= DATA_AREA_START.
  - control 3 WB_MEM: Rd <= data_from_memory.
  - control 4 ENTER_PRIV: privileged LR <= current PC.
  - control 5 RET_PRIV: PC <= privileged LR; this overrides should_branch and new_PC.
  - control 6–7: treated as NOP.
- Rd equal to PC_INDEX or SP_INDEX is silently ignored for controls 1 and 3. Rd equal to LR_INDEX writes the active-mode LR.
- enable = 0: no state change except the read registers.
- Reset asserted mid-sweep or mid-run: immediate return to the reset values and the sweep restarts from 0.
- The privileged_mode change takes effect on the same cycle's SP/LR selection; there is no latency.

Optional Feature:
- REGBANK_BYPASS_EN defined:
  - If a committing write in the same cycle targets register_source_X (including banked SP/LR and PC), read_data_X captures the new value.
  - Priority: PC write > SP write > Rd write.
- Undefined: read_data_X captures the pre-write value (old value).

Decomposition:
- Package regbank_pkg holds:
  - control enum: NOP, WB_ALU, CLR_STACK, WB_MEM, ENTER_PRIV, RET_PRIV.
  - FSM state enum: INIT, RUN.
  - A helper function mapping (index, privileged_mode) to physical slot.
- One natural sub-module: regbank_read_port, instantiated twice. It holds the address mux, banking remap, bypass compare and output register.

Test Plan:
- Reset, REG_COUNT=16 → busy high exactly 16 cycles; R0 = 8192, R5 = 0, SP = 0xFFFFFFFF, PC = 0 after busy falls.
- RUN, enable=1, control=1, Rd=3, ALU_result=0x1234, and register_source_A=3 the same cycle → read_data_A next cycle = 0x1234 with REGBANK_BYPASS_EN, old value without; following cycle = 0x1234 in both builds.
- control=1, Rd=15, ALU_result=0xDEAD, should_branch=0, new_PC=0x40 → PC = 0x40; Rd write dropped.
- privileged_mode=1, control=4 with PC=0x80, then control=5 two cycles later → privileged LR = 0x80 and PC returns to 0x80; user LR unchanged.
- privileged_mode=0, new_SP=0x100, then privileged_mode=1 with control=2 → user SP = 0x100, privileged SP = 0xFFFFFFFF, R0 = 8192.
- Assert reset at sweep cycle 7 and mid-RUN after writes → all outputs return to reset values asynchronously; busy runs a full 16 cycles again.

Source files
------------

// File: rtl/regbank_pkg.sv
// ============================================================================
// Module      : regbank_pkg
// Description : Shared types for the banked register file: write-back control
//               codes, sweep/run state encoding and the architectural-index to
//               physical-slot mapping used by the write and read paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regbank_pkg;

  // Write-back operation selected by the control input; codes 6 and 7 act as NOP
  typedef enum logic [2:0] {
    NOP        = 3'd0,
    WB_ALU     = 3'd1,
    CLR_STACK  = 3'd2,
    WB_MEM     = 3'd3,
    ENTER_PRIV = 3'd4,
    RET_PRIV   = 3'd5
  } ctrl_e;

  // Post-reset initialisation sweep, then normal operation
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Kind of physical storage an architectural index resolves to
  typedef enum logic [1:0] {
    SLOT_GPR = 2'd0,
    SLOT_SP  = 2'd1,
    SLOT_LR  = 2'd2,
    SLOT_PC  = 2'd3
  } slot_kind_e;

  // Physical slot: storage kind plus bank (1 = privileged copy, SP/LR only)
  typedef struct packed {
    slot_kind_e kind;
    logic       bank;
  } slot_t;

  // Resolve an architectural index under the current privilege mode
  function automatic slot_t map_slot(input int unsigned idx,
                                     input logic        priv,
                                     input int unsigned sp_idx,
                                     input int unsigned lr_idx,
                                     input int unsigned pc_idx);
    slot_t s;
    s.kind = SLOT_GPR;
    s.bank = 1'b0;
    if (idx == pc_idx) begin
      s.kind = SLOT_PC;
    end else if (idx == sp_idx) begin
      s.kind = SLOT_SP;
      s.bank = priv;
    end else if (idx == lr_idx) begin
      s.kind = SLOT_LR;
      s.bank = priv;
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regbank_read_port.sv
// ============================================================================
// Module      : regbank_read_port
// Description : One registered read port: address decode with SP/LR banking,
//               zero-extended PC view and an optional same-cycle write bypass.
//               Bypass is enabled by defining REGBANK_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int unsigned REG_COUNT       = 16,
  parameter int unsigned REGISTER_LENGTH = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned RI              = 4,
  parameter int unsigned SP_INDEX        = 14,
  parameter int unsigned LR_INDEX        = 13,
  parameter int unsigned PC_INDEX        = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       priv,
  input  logic [RI-1:0]              addr,
  input  logic [REGISTER_LENGTH-1:0] gpr [REG_COUNT],
  input  logic [REGISTER_LENGTH-1:0] sp_user,
  input  logic [REGISTER_LENGTH-1:0] sp_priv,
  input  logic [REGISTER_LENGTH-1:0] lr_user,
  input  logic [REGISTER_LENGTH-1:0] lr_priv,
  input  logic [ADDR_WIDTH-1:0]      pc,
  input  logic                       pc_we,
  input  logic [ADDR_WIDTH-1:0]      pc_d,
  input  logic                       sp_we,
  input  logic [REGISTER_LENGTH-1:0] sp_d,
  input  logic                       rd_we,
  input  logic [RI-1:0]              rd_idx,
  input  logic [REGISTER_LENGTH-1:0] rd_d,
  output logic [REGISTER_LENGTH-1:0] data
);

  slot_t                      w_slot;
  logic [REGISTER_LENGTH-1:0] w_stored;
  logic [REGISTER_LENGTH-1:0] w_next;

  assign w_slot = map_slot(32'(addr), priv, SP_INDEX, LR_INDEX, PC_INDEX);

  // Current stored value of the addressed slot, with banking applied
  always_comb begin
    w_stored = gpr[addr];
    case (w_slot.kind)
      SLOT_SP: w_stored = w_slot.bank ? sp_priv : sp_user;
      SLOT_LR: w_stored = w_slot.bank ? lr_priv : lr_user;
      SLOT_PC: w_stored = REGISTER_LENGTH'(pc);
      default: w_stored = gpr[addr];
    endcase
  end

`ifdef REGBANK_BYPASS_EN
  // Forward a committing write to the addressed slot; PC beats SP beats Rd
  always_comb begin
    w_next = w_stored;
    if (pc_we && (w_slot.kind == SLOT_PC)) begin
      w_next = REGISTER_LENGTH'(pc_d);
    end else if (sp_we && (w_slot.kind == SLOT_SP)) begin
      w_next = sp_d;
    end else if (rd_we && (addr == rd_idx)) begin
      w_next = rd_d;
    end
  end
`else
  // Without bypass the port always returns the pre-write value
  logic unused_bypass;
  assign unused_bypass = ^{pc_we, pc_d, sp_we, sp_d, rd_we, rd_idx, rd_d};

  always_comb begin
    w_next = w_stored;
  end
`endif

  // Output register; held at zero while the init sweep runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (!run) begin
      data <= '0;
    end else begin
      data <= w_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/banked_reg_file.sv
// ============================================================================
// Module      : banked_reg_file
// Description : Parametrised register file owning PC, banked SP and LR (user /
//               privileged), two registered read ports and a post-reset
//               initialisation sweep with busy flag. Define REGBANK_BYPASS_EN
//               to forward same-cycle writes to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_reg_file
  import regbank_pkg::*;
#(
  parameter int unsigned                  REG_COUNT       = 16,
  parameter int unsigned                  REGISTER_LENGTH = 32,
  parameter int unsigned                  ADDR_WIDTH      = 32,
  parameter int unsigned                  DATA_AREA_START = 8192,
  parameter logic [REGISTER_LENGTH-1:0]   MAX_NUMBER      = '1,
  parameter int unsigned                  SP_INDEX        = 14,
  parameter int unsigned                  LR_INDEX        = 13,
  parameter int unsigned                  PC_INDEX        = 15,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC        = '0,
  localparam int unsigned                 RI              = $clog2(REG_COUNT)
) (
  input  logic                       slow_clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       privileged_mode,
  input  logic [2:0]                 control,
  input  logic [RI-1:0]              register_source_A,
  input  logic [RI-1:0]              register_source_B,
  input  logic [RI-1:0]              register_Dest,
  input  logic [REGISTER_LENGTH-1:0] ALU_result,
  input  logic [REGISTER_LENGTH-1:0] data_from_memory,
  input  logic [REGISTER_LENGTH-1:0] new_SP,
  input  logic [ADDR_WIDTH-1:0]      new_PC,
  input  logic                       should_branch,
  output logic [REGISTER_LENGTH-1:0] read_data_A,
  output logic [REGISTER_LENGTH-1:0] read_data_B,
  output logic [ADDR_WIDTH-1:0]      current_PC,
  output logic [REGISTER_LENGTH-1:0] current_SP,
  output logic [REGISTER_LENGTH-1:0] memory_output,
  output logic                       busy
);

  localparam logic [REGISTER_LENGTH-1:0] c_data_area = REGISTER_LENGTH'(DATA_AREA_START);
  localparam logic [RI-1:0]              c_last_idx  = RI'(REG_COUNT - 1);
  localparam logic [RI-1:0]              c_lr_idx    = RI'(LR_INDEX);

  state_e                     r_state;
  state_e                     w_state_next;
  logic [RI-1:0]              r_sweep;
  logic [REGISTER_LENGTH-1:0] r_gpr [REG_COUNT];
  logic [REGISTER_LENGTH-1:0] r_sp  [2];
  logic [REGISTER_LENGTH-1:0] r_lr  [2];
  logic [ADDR_WIDTH-1:0]      r_pc;

  logic                       w_run;
  logic                       w_commit;
  slot_t                      w_rd_slot;
  slot_t                      w_sweep_slot;
  slot_t                      w_wr_slot;
  logic                       w_is_wb;
  logic [REGISTER_LENGTH-1:0] w_wb_data;
  logic [ADDR_WIDTH-1:0]      w_pc_next;
  logic [REGISTER_LENGTH-1:0] w_sp_next;
  logic                       w_wr_we;
  logic [RI-1:0]              w_wr_idx;
  logic [REGISTER_LENGTH-1:0] w_wr_data;
  logic                       w_gpr_we;
  logic                       w_lr_we;
  logic                       w_lr_bank;
  logic [REGISTER_LENGTH-1:0] w_lr_data;

  assign w_run        = (r_state == RUN);
  assign w_commit     = w_run && enable;
  assign busy         = (r_state == INIT);
  assign current_PC   = r_pc;
  assign current_SP   = r_sp[privileged_mode];
  assign w_rd_slot    = map_slot(32'(register_Dest), privileged_mode, SP_INDEX, LR_INDEX, PC_INDEX);
  assign w_sweep_slot = map_slot(32'(r_sweep), 1'b0, SP_INDEX, LR_INDEX, PC_INDEX);
  assign w_wr_slot    = map_slot(32'(w_wr_idx), privileged_mode, SP_INDEX, LR_INDEX, PC_INDEX);
  assign w_is_wb      = (control == WB_ALU) || (control == WB_MEM);
  assign w_wb_data    = (control == WB_MEM) ? data_from_memory : ALU_result;
  assign w_gpr_we     = w_wr_we && (w_wr_slot.kind == SLOT_GPR);

  // Sweep until the last index has been written, then run
  always_comb begin
    w_state_next = r_state;
    if ((r_state == INIT) && (r_sweep == c_last_idx)) begin
      w_state_next = RUN;
    end
  end

  // Next PC / active SP on a committing edge; return-from-privilege wins
  always_comb begin
    w_pc_next = should_branch ? ALU_result[ADDR_WIDTH-1:0] : new_PC;
    if (control == RET_PRIV) begin
      w_pc_next = r_lr[1][ADDR_WIDTH-1:0];
    end
    w_sp_next = (control == CLR_STACK) ? MAX_NUMBER : new_SP;
  end

  // Architecturally visible register write (GPR or active LR) of this cycle
  always_comb begin
    w_wr_we   = 1'b0;
    w_wr_idx  = register_Dest;
    w_wr_data = w_wb_data;
    if (w_commit) begin
      if (w_is_wb) begin
        w_wr_we = (w_rd_slot.kind == SLOT_GPR) || (w_rd_slot.kind == SLOT_LR);
      end else if (control == CLR_STACK) begin
        w_wr_we   = 1'b1;
        w_wr_idx  = '0;
        w_wr_data = c_data_area;
      end else if (control == ENTER_PRIV) begin
        // Only visible at LR_INDEX when the privileged bank is active
        w_wr_we   = privileged_mode;
        w_wr_idx  = c_lr_idx;
        w_wr_data = REGISTER_LENGTH'(r_pc);
      end
    end
  end

  // Link register update: Rd write to the active LR, or privileged entry
  always_comb begin
    w_lr_we   = 1'b0;
    w_lr_bank = privileged_mode;
    w_lr_data = w_wb_data;
    if (w_commit) begin
      if (control == ENTER_PRIV) begin
        w_lr_we   = 1'b1;
        w_lr_bank = 1'b1;
        w_lr_data = REGISTER_LENGTH'(r_pc);
      end else if (w_is_wb && (w_rd_slot.kind == SLOT_LR)) begin
        w_lr_we = 1'b1;
      end
    end
  end

  // Control state, PC and banked SP/LR with asynchronous reset
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_sweep <= '0;
      r_pc    <= RESET_PC;
      r_sp[0] <= MAX_NUMBER;
      r_sp[1] <= MAX_NUMBER;
      r_lr[0] <= '0;
      r_lr[1] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == INIT) begin
        r_sweep <= r_sweep + 1'b1;
      end
      if (w_commit) begin
        r_pc                  <= w_pc_next;
        r_sp[privileged_mode] <= w_sp_next;
        if (w_lr_we) begin
          r_lr[w_lr_bank] <= w_lr_data;
        end
      end
    end
  end

  // General registers: cleared by the sweep, then written by write-back
  always_ff @(posedge slow_clock) begin
    if (r_state == INIT) begin
      if (w_sweep_slot.kind == SLOT_GPR) begin
        r_gpr[r_sweep] <= (r_sweep == '0) ? c_data_area : '0;
      end
    end else if (w_gpr_we) begin
      r_gpr[w_wr_idx] <= w_wr_data;
    end
  end

  // Combinational store-data view of Rd with banking applied
  always_comb begin
    memory_output = r_gpr[register_Dest];
    case (w_rd_slot.kind)
      SLOT_SP: memory_output = r_sp[w_rd_slot.bank];
      SLOT_LR: memory_output = r_lr[w_rd_slot.bank];
      SLOT_PC: memory_output = REGISTER_LENGTH'(r_pc);
      default: memory_output = r_gpr[register_Dest];
    endcase
  end

  regbank_read_port #(
    .REG_COUNT      (REG_COUNT),
    .REGISTER_LENGTH(REGISTER_LENGTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .RI             (RI),
    .SP_INDEX       (SP_INDEX),
    .LR_INDEX       (LR_INDEX),
    .PC_INDEX       (PC_INDEX)
  ) u_read_a (
    .clk    (slow_clock),
    .rst    (reset),
    .run    (w_run),
    .priv   (privileged_mode),
    .addr   (register_source_A),
    .gpr    (r_gpr),
    .sp_user(r_sp[0]),
    .sp_priv(r_sp[1]),
    .lr_user(r_lr[0]),
    .lr_priv(r_lr[1]),
    .pc     (r_pc),
    .pc_we  (w_commit),
    .pc_d   (w_pc_next),
    .sp_we  (w_commit),
    .sp_d   (w_sp_next),
    .rd_we  (w_wr_we),
    .rd_idx (w_wr_idx),
    .rd_d   (w_wr_data),
    .data   (read_data_A)
  );

  regbank_read_port #(
    .REG_COUNT      (REG_COUNT),
    .REGISTER_LENGTH(REGISTER_LENGTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .RI             (RI),
    .SP_INDEX       (SP_INDEX),
    .LR_INDEX       (LR_INDEX),
    .PC_INDEX       (PC_INDEX)
  ) u_read_b (
    .clk    (slow_clock),
    .rst    (reset),
    .run    (w_run),
    .priv   (privileged_mode),
    .addr   (register_source_B),
    .gpr    (r_gpr),
    .sp_user(r_sp[0]),
    .sp_priv(r_sp[1]),
    .lr_user(r_lr[0]),
    .lr_priv(r_lr[1]),
    .pc     (r_pc),
    .pc_we  (w_commit),
    .pc_d   (w_pc_next),
    .sp_we  (w_commit),
    .sp_d   (w_sp_next),
    .rd_we  (w_wr_we),
    .rd_idx (w_wr_idx),
    .rd_d   (w_wr_data),
    .data   (read_data_B)
  );

endmodule

`default_nettype wire
